wb_scoreboard: RTL and testbench

Write-back arbiter and register scoreboard for the integer register file. It merges the in-order pipeline write-back with results from variable-latency units (divider, FPU, I/O loads) onto the register file's single write port. Results that cannot be written immediately go through a small result buffer. It also tracks the registers that still have an outstanding long-latency write and stalls the decode stage on RAW/WAW hazards against them. It sits between the write-back stage, the long-latency units and the decode stage's register file.

---
 rtl/wb_scoreboard.sv | 191 +++++++++++++++++++
 tb/tb_wb_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// Purpose : merge pipeline write-back and buffered long-unit results onto the RF write port; track pending long writes.
// Latency : pipeline write is combinational (same cycle); a long result is written at least one cycle after acceptance.
// Backpr. : lu_ready = !full (0 in reset); decode stalls on pending hazards, or on starvation when WB_STARVE_GUARD_EN is defined.

// Small synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// Top: write-port arbiter plus per-register pending scoreboard.
module wb_scoreboard #(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        use_rs1_d,
  input  logic        use_rs2_d,
  input  logic        use_rd_d,
  output logic        stall_d,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd
);
  localparam int EW = 37;

  logic          pipe_win;
  logic          buf_empty;
  logic          buf_full;
  logic          buf_push;
  logic          buf_pop;
  logic          throttle;
  logic [EW-1:0] head;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic          set_vld;
  logic          hz_rs1;
  logic          hz_rs2;
  logic          hz_rd;

  // A write to x0 is a no-op, so it never claims the port.
  assign pipe_win = !rst && reg_write_w && (rd_w != 5'd0);
  assign lu_ready = !rst && !buf_full;
  // x0 results are handshaken but dropped so they never occupy the buffer.
  assign buf_push = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign buf_pop  = !rst && !pipe_win && !buf_empty;
  assign set_vld  = issue_valid && issue_long && (issue_rd != 5'd0);
  assign {head_rd, head_data} = head;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LU_DEPTH)
  ) u_result_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   ({lu_rd, lu_data}),
    .dout  (head),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // Write-port mux: pipeline first, then buffer head, else idle with zeroed address/data.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_wd   = 32'd0;
    if (pipe_win) begin
      rf_we   = 1'b1;
      rf_addr = rd_w;
      rf_wd   = result_w;
    end else if (buf_pop) begin
      rf_we   = 1'b1;
      rf_addr = head_rd;
      rf_wd   = head_data;
    end
  end

  // Next pending vector: the buffer's write clears, a new long issue sets, and set is applied last so it wins.
  always_comb begin
    pending_nxt = pending;
    if (buf_pop) pending_nxt[head_rd] = 1'b0;
    if (set_vld) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending register; everything outstanding is forgotten on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // A used, non-zero field hazards on a pending register unless that register is being written from the buffer right now.
  function automatic logic hazard(input logic used, input logic [4:0] r, input logic [31:0] pend,
                                  input logic clr_vld, input logic [4:0] clr_rd);
    return used && (r != 5'd0) && pend[r] && !(clr_vld && (clr_rd == r));
  endfunction

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = STARVE_MAX[CW-1:0];
  logic [CW-1:0] starve_cnt;

  // Count cycles the buffer head loses the port; saturate, and restart whenever it drains or pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (buf_pop || buf_empty) begin
      starve_cnt <= '0;
    end else if (pipe_win && (starve_cnt != SMAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign throttle = (starve_cnt == SMAX);
`else
  assign throttle = 1'b0;
`endif

  // Decode stall: any field hazard, or the starvation throttle.
  always_comb begin
    hz_rs1  = hazard(use_rs1_d, rs1_d, pending, buf_pop, head_rd);
    hz_rs2  = hazard(use_rs2_d, rs2_d, pending, buf_pop, head_rd);
    hz_rd   = hazard(use_rd_d,  rd_d,  pending, buf_pop, head_rd);
    stall_d = hz_rs1 || hz_rs2 || hz_rd || throttle;
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Purpose : self-checking bench for wb_scoreboard (vector table, directed corner sequences, random vs queue model).
// Latency : inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpr. : long-unit requests are held until accepted; decode issues only when the model says it is not stalled.
module tb_wb_scoreboard;
  localparam int LU_DEPTH   = 2;
  localparam int STARVE_MAX = 8;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, rs1_d, rs2_d, rd_d;
  logic        use_rs1_d, use_rs2_d, use_rd_d;
  logic        stall_d;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  wb_scoreboard #(.LU_DEPTH(LU_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .use_rd_d(use_rd_d),
    .stall_d(stall_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending registers, result queue, starvation age.
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  bit   m_pend [32];
  ent_t m_q [$];
  int   m_starve;

  // DUT outputs as seen at the last falling edge, plus whether the long unit was accepted.
  logic        s_stall, s_ready, s_we;
  logic [4:0]  s_addr;
  logic [31:0] s_wd;
  logic        last_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic blocks(input logic u, input logic [4:0] r, input logic [4:0] clr);
    return u && (r != 5'd0) && m_pend[r] && (r != clr);
  endfunction

  function automatic void model_eval(output logic e_stall, output logic e_ready, output logic e_we,
                                     output logic [4:0] e_addr, output logic [31:0] e_wd, output logic e_pop);
    logic       pipe;
    logic [4:0] clr;
    pipe    = reg_write_w && (rd_w != 5'd0);
    e_ready = (m_q.size() < LU_DEPTH);
    e_pop   = !pipe && (m_q.size() != 0);
    e_we    = 1'b0;
    e_addr  = 5'd0;
    e_wd    = 32'd0;
    clr     = 5'd0;
    if (pipe) begin
      e_we = 1'b1; e_addr = rd_w; e_wd = result_w;
    end else if (e_pop) begin
      e_we = 1'b1; e_addr = m_q[0].rd; e_wd = m_q[0].data; clr = m_q[0].rd;
    end
    e_stall = blocks(use_rs1_d, rs1_d, clr) || blocks(use_rs2_d, rs2_d, clr) ||
              blocks(use_rd_d, rd_d, clr) || (GUARD && (m_starve >= STARVE_MAX));
  endfunction

  function automatic void model_update(input logic e_pop, input logic e_ready);
    int n;
    n = m_q.size();
    if (e_pop) m_pend[m_q[0].rd] = 1'b0;
    if (n == 0 || e_pop) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    if (e_pop) void'(m_q.pop_front());
    if (issue_valid && issue_long && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    if (lu_valid && e_ready && lu_rd != 5'd0) m_q.push_back({lu_rd, lu_data});
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_q.delete();
    m_starve = 0;
  endfunction

  task automatic set_idle();
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
    use_rs1_d = 0; use_rs2_d = 0; use_rd_d = 0;
    reg_write_w = 0; rd_w = 0; result_w = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  // One clock: compare every output against the model at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    logic e_stall, e_ready, e_we, e_pop;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    model_eval(e_stall, e_ready, e_we, e_addr, e_wd, e_pop);
    s_stall = stall_d; s_ready = lu_ready; s_we = rf_we; s_addr = rf_addr; s_wd = rf_wd;
    check("stall_d", 32'(stall_d), 32'(e_stall));
    check("lu_ready", 32'(lu_ready), 32'(e_ready));
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("rf_addr", 32'(rf_addr), 32'(e_addr));
    check("rf_wd", rf_wd, e_wd);
    check("wb_to_pending", 32'(reg_write_w && rd_w != 5'd0 && m_pend[rd_w]), 32'd0);
    last_acc = lu_valid && e_ready;
    @(posedge clk);
    model_update(e_pop, e_ready);
    #1;
  endtask

  // Assert reset asynchronously (inputs left as the caller set them), check the reset outputs, release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_clear();
    last_acc = 1'b0;
    @(negedge clk);
    check({tag, "_lu_ready"}, 32'(lu_ready), 32'd0);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_stall_d"}, 32'(stall_d), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic iv; logic il; logic [4:0] ird; logic [4:0] rs1; logic u1;
    logic rw; logic [4:0] rdw; logic [31:0] resw;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic es; logic er; logic ew; logic [4:0] ea; logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic il, input logic [4:0] ird, input logic [4:0] rs1, input logic u1,
                              input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                              input logic es, input logic er, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.iv = iv; v.il = il; v.ird = ird; v.rs1 = rs1; v.u1 = u1;
    v.rw = rw; v.rdw = rdw; v.resw = resw;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.es = es; v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    logic e_stall, e_ready, e_we, e_pop;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [4:0]  r;

    // issue x5 long, stall on rs1=x5, result arrives, written next cycle with stall released
    vt[0]  = mk(1'b1,1'b1,5'd5, 5'd0,1'b0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b0,5'd0,32'h0);
    vt[1]  = mk(1'b0,1'b0,5'd0, 5'd5,1'b1, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b1,1'b1,1'b0,5'd0,32'h0);
    vt[2]  = mk(1'b0,1'b0,5'd0, 5'd5,1'b1, 1'b0,5'd0,32'h0,    1'b1,5'd5,32'h1234,  1'b1,1'b1,1'b0,5'd0,32'h0);
    vt[3]  = mk(1'b0,1'b0,5'd0, 5'd5,1'b1, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b1,5'd5,32'h1234);
    vt[4]  = mk(1'b0,1'b0,5'd0, 5'd5,1'b1, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b0,5'd0,32'h0);
    // x7 result held behind three pipeline writes to x3
    vt[5]  = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b1,5'd3,32'hA0,   1'b1,5'd7,32'h77,    1'b0,1'b1,1'b1,5'd3,32'hA0);
    vt[6]  = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b1,5'd3,32'hA1,   1'b0,5'd0,32'h0,     1'b0,1'b1,1'b1,5'd3,32'hA1);
    vt[7]  = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b1,5'd3,32'hA2,   1'b0,5'd0,32'h0,     1'b0,1'b1,1'b1,5'd3,32'hA2);
    vt[8]  = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b1,5'd7,32'h77);
    vt[9]  = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b0,5'd0,32'h0);
    // x0 result is discarded; x0 never stalls; pipeline write to x0 is not a write
    vt[10] = mk(1'b0,1'b0,5'd0, 5'd0,1'b1, 1'b0,5'd0,32'h0,    1'b1,5'd0,32'hDEAD,  1'b0,1'b1,1'b0,5'd0,32'h0);
    vt[11] = mk(1'b0,1'b0,5'd0, 5'd0,1'b1, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,     1'b0,1'b1,1'b0,5'd0,32'h0);
    vt[12] = mk(1'b0,1'b0,5'd0, 5'd0,1'b0, 1'b1,5'd0,32'hBEEF, 1'b0,5'd0,32'h0,     1'b0,1'b1,1'b0,5'd0,32'h0);

    set_idle();
    model_clear();
    last_acc = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Vector table
    for (int i = 0; i < 13; i++) begin
      set_idle();
      issue_valid = vt[i].iv; issue_long = vt[i].il; issue_rd = vt[i].ird;
      rs1_d = vt[i].rs1; use_rs1_d = vt[i].u1;
      reg_write_w = vt[i].rw; rd_w = vt[i].rdw; result_w = vt[i].resw;
      lu_valid = vt[i].lv; lu_rd = vt[i].lrd; lu_data = vt[i].ldat;
      tick();
      check($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vt[i].es));
      check($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vt[i].er));
      check($sformatf("vec%0d_we", i), 32'(s_we), 32'(vt[i].ew));
      check($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(vt[i].ea));
      check($sformatf("vec%0d_wd", i), s_wd, vt[i].ed);
    end

    // Buffer full while the pipeline owns the port: third result held, accepted after the first pop
    set_idle();
    reg_write_w = 1; rd_w = 5'd1; result_w = 32'h11;
    lu_valid = 1; lu_rd = 5'd10; lu_data = 32'hA10;
    tick();
    lu_rd = 5'd11; lu_data = 32'hA11;
    tick();
    lu_rd = 5'd12; lu_data = 32'hA12;
    tick();
    check("full_ready_low", 32'(s_ready), 32'd0);
    tick();
    check("full_ready_held", 32'(s_ready), 32'd0);
    reg_write_w = 0;
    tick();
    check("full_pop_ready", 32'(s_ready), 32'd0);
    check("full_pop_addr", 32'(s_addr), 32'd10);
    tick();
    check("full_accept_ready", 32'(s_ready), 32'd1);
    check("full_pop2_addr", 32'(s_addr), 32'd11);
    lu_valid = 0;
    tick();
    check("full_pop3_addr", 32'(s_addr), 32'd12);
    check("full_pop3_wd", s_wd, 32'hA12);
    tick();

    // Starvation: one buffered result behind continuous pipeline writes
    set_idle();
    reg_write_w = 1; rd_w = 5'd2; result_w = 32'h22;
    lu_valid = 1; lu_rd = 5'd20; lu_data = 32'h2020;
    tick();
    lu_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == STARVE_MAX) check("starve_before", 32'(s_stall), 32'd0);
      if (k == STARVE_MAX + 1) check("starve_throttle", 32'(s_stall), 32'(GUARD));
    end
    reg_write_w = 0;
    tick();
    check("starve_pop_addr", 32'(s_addr), 32'd20);
    tick();
    check("starve_released", 32'(s_stall), 32'd0);

    // Reset mid-operation with x9 pending and two buffered results
    set_idle();
    issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
    reg_write_w = 1; rd_w = 5'd1; result_w = 32'h33;
    lu_valid = 1; lu_rd = 5'd21; lu_data = 32'h21;
    tick();
    issue_valid = 0; issue_long = 0;
    lu_rd = 5'd22; lu_data = 32'h22;
    tick();
    lu_valid = 0;
    use_rs1_d = 1; rs1_d = 5'd9;
    tick();
    check("pre_rst_stall", 32'(s_stall), 32'd1);
    check("pre_rst_full", 32'(s_ready), 32'd0);
    do_reset("midrst");
    set_idle();
    use_rs1_d = 1; rs1_d = 5'd9;
    tick();
    check("post_rst_stall", 32'(s_stall), 32'd0);
    check("post_rst_we", 32'(s_we), 32'd0);
    check("post_rst_ready", 32'(s_ready), 32'd1);

    // Randomized traffic against the model
    set_idle();
    for (int c = 0; c < 3000; c++) begin
      rs1_d = 5'($urandom_range(0, 31)); rs2_d = 5'($urandom_range(0, 31)); rd_d = 5'($urandom_range(0, 31));
      use_rs1_d = 1'($urandom_range(0, 1)); use_rs2_d = 1'($urandom_range(0, 1)); use_rd_d = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      rd_w = 5'($urandom_range(0, 31));
      if (m_pend[rd_w]) rd_w = 5'd0;
      result_w = $urandom;
      if (!(lu_valid && !last_acc)) begin
        lu_valid = ($urandom_range(0, 2) == 0);
        r = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 1) == 1) begin
          for (int j = 0; j < 31; j++) begin
            if (!m_pend[r]) r = (r == 5'd31) ? 5'd1 : r + 5'd1;
          end
        end
        lu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : r;
        lu_data = $urandom;
      end
      issue_valid = 0;
      issue_long = 1'($urandom_range(0, 1));
      issue_rd = rd_d;
      model_eval(e_stall, e_ready, e_we, e_addr, e_wd, e_pop);
      if (!e_stall && $urandom_range(0, 2) == 0) issue_valid = 1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
